// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a memory-mapped read-to-clear byte register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int          BAUD_DIV = 651,
  parameter logic [15:0] RX_READ  = 16'h0112
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        ack,
  input  logic        rxin,
  output logic [7:0]  rxdata,
  output logic        irq,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err,
  output logic [2:0]  state,
  output logic [3:0]  tickctr
);
  localparam int DW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t st, nst;
  logic rx_m, rxs, rxs_d;
  logic [DW-1:0] div;
  logic [2:0] bitctr;
  logic [7:0] shreg;
  logic tick, mid7, wrap, to_data, shift, stop_smp, good, rd, par_bad;
  assign tick = div == DW'(BAUD_DIV - 1);
  assign mid7 = tick && tickctr == 4'd7;
  assign wrap = tick && tickctr == 4'd15;
  assign rd = addr == RX_READ;
  assign good = stop_smp && rxs && !par_bad;
  assign state = st;
  // rxs_d only feeds the start-edge detector
  always_ff @(posedge clk or negedge rst)
    if (!rst) {rx_m, rxs, rxs_d} <= '1;
    else {rx_m, rxs, rxs_d} <= {rxin, rx_m, rxs};
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nst;
  always_comb begin
    nst = st;
    case (st)
      IDLE:   nst = rxs_d && !rxs ? START : IDLE;
      START:  nst = mid7 ? (rxs ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:   nst = wrap && bitctr == 3'd7 ? PARITY : DATA;
      PARITY: nst = wrap ? STOP : PARITY;
`else
      DATA:   nst = wrap && bitctr == 3'd7 ? STOP : DATA;
`endif
      STOP:   nst = wrap ? IDLE : STOP;
      default: nst = IDLE;
    endcase
  end
  always_comb begin
    to_data = st == START && mid7 && !rxs;
    shift = st == DATA && wrap;
    stop_smp = st == STOP && wrap;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div <= '0;
      tickctr <= '0;
      bitctr <= '0;
      shreg <= '0;
    end else begin
      div <= st == IDLE || tick ? '0 : div + 1'b1;
      tickctr <= st == IDLE || to_data ? '0 : tickctr + 4'(tick);
      bitctr <= to_data ? '0 : bitctr + 3'(shift);
      if (shift) shreg <= {rxs, shreg[7:1]};
    end
  // a read in the same cycle as a new byte frees the slot, so no overrun
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rxdata <= '0;
      irq <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (good && (!irq || rd)) rxdata <= shreg;
      irq <= good || (irq && !rd);
      frame_err <= (frame_err && !ack) || (stop_smp && !rxs);
      overrun <= (overrun && !ack) || (good && irq && !rd);
    end
`ifdef UART_RX_PARITY_EN
  logic par_smp, par_bit_bad;
  assign par_smp = st == PARITY && wrap;
  assign par_bit_bad = rxs != ^shreg;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      par_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad <= to_data ? 1'b0 : (par_smp ? par_bit_bad : par_bad);
      parity_err <= (parity_err && !ack) || (par_smp && par_bit_bad);
    end
`else
  assign par_bad = 1'b0;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame-level check of uart_rx against a byte/flag reference model.
module tb_uart_rx;
  localparam int BD = 4;
  localparam logic [15:0] RD = 16'h0112;
  localparam int BIT = 16 * BD;
  logic clk = 1'b0, rst = 1'b1, ack = 1'b0, rxin = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0] rxdata;
  logic irq, frame_err, overrun, parity_err;
  logic [2:0] state;
  logic [3:0] tickctr;
  int checks = 0, errors = 0;
  logic [7:0] m_data = '0;
  logic m_irq = 0, m_fe = 0, m_ov = 0, m_pe = 0;
  uart_rx #(.BAUD_DIV(BD), .RX_READ(RD)) dut (
    .clk(clk), .rst(rst), .addr(addr), .ack(ack), .rxin(rxin),
    .rxdata(rxdata), .irq(irq), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .state(state), .tickctr(tickctr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_rxdata"}, 32'(rxdata), 32'(m_data));
    chk({tag, "_irq"}, 32'(irq), 32'(m_irq));
    chk({tag, "_fe"}, 32'(frame_err), 32'(m_fe));
    chk({tag, "_ov"}, 32'(overrun), 32'(m_ov));
    chk({tag, "_pe"}, 32'(parity_err), 32'(m_pe));
    chk({tag, "_state"}, 32'(state), 32'd0);
  endtask
  task automatic do_read();
    addr = RD;
    cyc(1);
    addr = '0;
    m_irq = 0;
  endtask
  task automatic do_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    {m_fe, m_ov, m_pe} = '0;
  endtask
  task automatic send(input string tag, input logic [7:0] b, input logic stop, input logic par);
    logic good;
    rxin = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxin = b[i];
      cyc(BIT);
    end
    good = stop;
`ifdef UART_RX_PARITY_EN
    rxin = par;
    cyc(BIT);
    if (par != ^b) begin
      m_pe = 1;
      good = 0;
    end
`endif
    rxin = stop;
    cyc(20);
    chk({tag, "_irq_early"}, 32'(irq), 32'(m_irq));
    cyc(BIT - 20);
    if (!stop) m_fe = 1;
    if (good) begin
      if (m_irq) m_ov = 1;
      else begin
        m_data = b;
        m_irq = 1;
      end
    end
    check_all(tag);
    rxin = 1'b1;
    cyc(4);
  endtask
  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_async_state", 32'(state), 32'd0);
    cyc(3);
    check_all("reset");
    chk("reset_tickctr", 32'(tickctr), 32'd0);
    rst = 1'b1;
    cyc(4);
    send("a5", 8'hA5, 1'b1, ^8'hA5);
    do_read();
    rxin = 1'b0;
    cyc(5 * BD);
    rxin = 1'b1;
    cyc(BIT + 20);
    check_all("false_start");
    send("3c_fe", 8'h3C, 1'b0, ^8'h3C);
    do_ack();
    check_all("3c_ack");
    send("11", 8'h11, 1'b1, ^8'h11);
    send("22_ov", 8'h22, 1'b1, ^8'h22);
    do_read();
    check_all("read");
    send("33", 8'h33, 1'b1, ^8'h33);
    rxin = 1'b0;
    cyc(BIT);
    rxin = 1'b1;
    cyc(4 * BIT + BIT / 2);
    rst = 1'b0;
    #1;
    {m_data, m_irq, m_fe, m_ov, m_pe} = '0;
    check_all("midrst");
    chk("midrst_tickctr", 32'(tickctr), 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(6 * BIT);
    check_all("after_rst");
    send("5a", 8'h5A, 1'b1, ^8'h5A);
    do_read();
`ifdef UART_RX_PARITY_EN
    send("07_badpar", 8'h07, 1'b1, 1'b0);
    do_ack();
    send("07_goodpar", 8'h07, 1'b1, 1'b1);
    do_read();
`endif
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send("rnd", b, $urandom_range(0, 7) != 0, (^b) ^ ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) != 0) do_read();
      if ($urandom_range(0, 3) == 0) do_ack();
      cyc($urandom_range(1, 10));
    end
    check_all("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
